// File: rtl/perimeter_pkg.sv
// Shared definitions for the perimeter unit and its downstream stages:
// the perimeter result width, the accumulator handshake state encoding and
// a small unsigned max helper.
package perimeter_pkg;

  localparam int PERIM_W = 10;

  typedef enum logic [1:0] {
    S_IN_WAIT = 2'd0,
    S_IN_ACK  = 2'd1,
    S_OUT_RDY = 2'd2,
    S_OUT_ACK = 2'd3
  } acc_state_t;

  function automatic logic [PERIM_W-1:0] max_of(input logic [PERIM_W-1:0] a,
                                                input logic [PERIM_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/perimeter_accumulator.sv
// Downstream accumulator for the perimeter unit. Takes N results over the
// dav_/rfd four-phase handshake, sums them and hands the sum on over the same
// handshake, holding off upstream (rfd_in low) while a sum is pending.
// Optional feature: define PERIMETER_ACCUMULATOR_MAX_EN to add the max_out
// port, which reports the largest sample of each completed group.
module perimeter_accumulator
  import perimeter_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int DATA_W = PERIM_W,
  localparam int SUM_W  = DATA_W + $clog2(N)
) (
  input  logic              clock,
  input  logic              reset_,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dav_in_,
  output logic              rfd_in,
  output logic [SUM_W-1:0]  data_out,
  output logic              dav_out_,
  input  logic              rfd_out
`ifdef PERIMETER_ACCUMULATOR_MAX_EN
  ,
  output logic [DATA_W-1:0] max_out
`endif
);

  localparam int CNT_W = $clog2(N + 1);

  acc_state_t        state;
  logic [SUM_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
`ifdef PERIMETER_ACCUMULATOR_MAX_EN
  logic [DATA_W-1:0] max_acc;
`endif

  // Handshake FSM: accept one sample per input four-phase cycle, publish the
  // sum after the N-th sample, clear the group once downstream acknowledges.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state    <= S_IN_WAIT;
      rfd_in   <= 1'b1;
      dav_out_ <= 1'b1;
      data_out <= '0;
      acc      <= '0;
      cnt      <= '0;
`ifdef PERIMETER_ACCUMULATOR_MAX_EN
      max_acc  <= '0;
      max_out  <= '0;
`endif
    end else begin
      case (state)
        S_IN_WAIT: begin
          if (!dav_in_) begin
            acc     <= acc + SUM_W'(data_in);
            cnt     <= cnt + CNT_W'(1);
            rfd_in  <= 1'b0;
`ifdef PERIMETER_ACCUMULATOR_MAX_EN
            max_acc <= max_of(max_acc, data_in);
`endif
            state   <= S_IN_ACK;
          end
        end
        // Staying here while dav_in_ is held low keeps a sample from being
        // counted twice.
        S_IN_ACK: begin
          if (dav_in_) begin
            if (cnt == CNT_W'(N)) begin
              data_out <= acc;
`ifdef PERIMETER_ACCUMULATOR_MAX_EN
              max_out  <= max_acc;
`endif
              state    <= S_OUT_RDY;
            end else begin
              rfd_in   <= 1'b1;
              state    <= S_IN_WAIT;
            end
          end
        end
        S_OUT_RDY: begin
          if (rfd_out) begin
            dav_out_ <= 1'b0;
            state    <= S_OUT_ACK;
          end
        end
        // data_out is deliberately not cleared: it holds until the next group.
        S_OUT_ACK: begin
          if (!rfd_out) begin
            dav_out_ <= 1'b1;
            acc      <= '0;
            cnt      <= '0;
`ifdef PERIMETER_ACCUMULATOR_MAX_EN
            max_acc  <= '0;
`endif
            rfd_in   <= 1'b1;
            state    <= S_IN_WAIT;
          end
        end
        default: begin
          state <= S_IN_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perimeter_accumulator.sv
// Self-checking bench for perimeter_accumulator (N=4). A queue-based model
// groups accepted samples into fours and predicts each sum (and max, when
// PERIMETER_ACCUMULATOR_MAX_EN is defined).
module tb_perimeter_accumulator;

  localparam int N     = 4;
  localparam int DW    = 10;
  localparam int SW    = 12;
  localparam int TMO   = 50;

  logic          clock;
  logic          reset_;
  logic [DW-1:0] data_in;
  logic          dav_in_;
  logic          rfd_in;
  logic [SW-1:0] data_out;
  logic          dav_out_;
  logic          rfd_out;
`ifdef PERIMETER_ACCUMULATOR_MAX_EN
  logic [DW-1:0] max_out;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  int unsigned grp[$];
  int unsigned exp_sum[$];
  int unsigned exp_max[$];

  perimeter_accumulator #(.N(N), .DATA_W(DW)) dut (
    .clock    (clock),
    .reset_   (reset_),
    .data_in  (data_in),
    .dav_in_  (dav_in_),
    .rfd_in   (rfd_in),
    .data_out (data_out),
    .dav_out_ (dav_out_),
    .rfd_out  (rfd_out)
`ifdef PERIMETER_ACCUMULATOR_MAX_EN
    ,
    .max_out  (max_out)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void model_accept(input int unsigned v);
    int unsigned s;
    int unsigned m;
    grp.push_back(v);
    if (grp.size() == N) begin
      s = 0;
      m = 0;
      foreach (grp[i]) begin
        s += grp[i];
        if (grp[i] > m) m = grp[i];
      end
      exp_sum.push_back(s);
      exp_max.push_back(m);
      grp.delete();
    end
  endfunction

  function automatic void model_reset();
    grp.delete();
    exp_sum.delete();
    exp_max.delete();
  endfunction

  // Full four-phase input transfer of one value; lat = clocks from dav_in_
  // low until rfd_in low.
  task automatic send_value(input logic [DW-1:0] v, output int lat);
    int n;
    n = 0;
    while (rfd_in !== 1'b1 && n < TMO) begin
      tick();
      n++;
    end
    checks++;
    if (rfd_in !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: rfd_in=%b required 1", rfd_in);
    end
    data_in = v;
    dav_in_ = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (rfd_in !== 1'b0 && n < TMO);
    lat = n;
    checks++;
    if (rfd_in !== 1'b0) begin
      errors++;
      $display("FAIL send_ack: rfd_in=%b required 0", rfd_in);
    end
    dav_in_ = 1'b1;
    tick();
    model_accept(v);
  endtask

  // Full four-phase output transfer, checked against the model.
  task automatic recv_check(input string name);
    int unsigned es;
    int unsigned em;
    int n;
    es = 0;
    em = 0;
    checks++;
    if (exp_sum.size() == 0) begin
      errors++;
      $display("FAIL %s_model: no sum expected, 0 queued sums required >=1", name);
    end else begin
      es = exp_sum.pop_front();
      em = exp_max.pop_front();
    end
    rfd_out = 1'b1;
    n = 0;
    while (dav_out_ !== 1'b0 && n < TMO) begin
      tick();
      n++;
    end
    checks++;
    if (dav_out_ !== 1'b0) begin
      errors++;
      $display("FAIL %s_dav: dav_out_=%b required 0", name, dav_out_);
    end
    checks++;
    if (data_out !== SW'(es)) begin
      errors++;
      $display("FAIL %s_sum: data_out=%0d required %0d", name, data_out, es);
    end
`ifdef PERIMETER_ACCUMULATOR_MAX_EN
    checks++;
    if (max_out !== DW'(em)) begin
      errors++;
      $display("FAIL %s_max: max_out=%0d required %0d", name, max_out, em);
    end
`endif
    rfd_out = 1'b0;
    n = 0;
    while (dav_out_ !== 1'b1 && n < TMO) begin
      tick();
      n++;
    end
    checks++;
    if (dav_out_ !== 1'b1 || rfd_in !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: dav_out_=%b rfd_in=%b required 1 1", name, dav_out_, rfd_in);
    end
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    #3;
    checks++;
    if (rfd_in !== 1'b1 || dav_out_ !== 1'b1 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_vals: rfd_in=%b dav_out_=%b data_out=%0d required 1 1 0",
               rfd_in, dav_out_, data_out);
    end
`ifdef PERIMETER_ACCUMULATOR_MAX_EN
    checks++;
    if (max_out !== '0) begin
      errors++;
      $display("FAIL reset_max: max_out=%0d required 0", max_out);
    end
`endif
    tick();
    tick();
    #2;
    reset_ = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_basic();
    int lat;
    int unsigned es;
    logic [DW-1:0] vals [4];
    vals = '{10'd20, 10'd30, 10'd40, 10'd50};
    rfd_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_value(vals[i], lat);
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL basic_latency: rfd_in fell after %0d clocks required 1", lat);
      end
    end
    es = exp_sum.pop_front();
    void'(exp_max.pop_front());
    checks++;
    if (data_out !== SW'(140) || data_out !== SW'(es) || dav_out_ !== 1'b1) begin
      errors++;
      $display("FAIL basic_sum: data_out=%0d dav_out_=%b required 140 1", data_out, dav_out_);
    end
    tick();
    checks++;
    if (dav_out_ !== 1'b0) begin
      errors++;
      $display("FAIL basic_dav: dav_out_=%b required 0", dav_out_);
    end
    rfd_out = 1'b0;
    tick();
    checks++;
    if (dav_out_ !== 1'b1 || rfd_in !== 1'b1 || data_out !== SW'(140)) begin
      errors++;
      $display("FAIL basic_release: dav_out_=%b rfd_in=%b data_out=%0d required 1 1 140",
               dav_out_, rfd_in, data_out);
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    rfd_out = 1'b0;
    for (int i = 0; i < 4; i++) send_value(DW'(5 + i), lat);
    data_in = 10'd77;
    dav_in_ = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (rfd_in !== 1'b0 || dav_out_ !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: rfd_in=%b dav_out_=%b required 0 1", rfd_in, dav_out_);
    end
    rfd_out = 1'b1;
    tick();
    checks++;
    if (dav_out_ !== 1'b0 || data_out !== SW'(exp_sum[0])) begin
      errors++;
      $display("FAIL bp_deliver: dav_out_=%b data_out=%0d required 0 %0d",
               dav_out_, data_out, exp_sum[0]);
    end
    void'(exp_sum.pop_front());
    void'(exp_max.pop_front());
    rfd_out = 1'b0;
    tick();
    checks++;
    if (dav_out_ !== 1'b1 || rfd_in !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: dav_out_=%b rfd_in=%b required 1 1", dav_out_, rfd_in);
    end
    tick();
    checks++;
    if (rfd_in !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept5: rfd_in=%b required 0", rfd_in);
    end
    dav_in_ = 1'b1;
    tick();
    model_accept(77);
    for (int i = 0; i < 3; i++) send_value(10'd1, lat);
    recv_check("bp_next");
  endtask

  task automatic test_extremes();
    int lat;
    for (int i = 0; i < 4; i++) send_value(10'd1023, lat);
    checks++;
    if (data_out !== 12'hFFC) begin
      errors++;
      $display("FAIL ext_max_sum: data_out=%0d required 4092", data_out);
    end
    recv_check("ext_full");
    for (int i = 0; i < 4; i++) send_value(10'd0, lat);
    recv_check("ext_zero");
  endtask

  task automatic test_held_dav();
    int lat;
    data_in = 10'd100;
    dav_in_ = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (rfd_in !== 1'b0) begin
      errors++;
      $display("FAIL held_rfd: rfd_in=%b required 0", rfd_in);
    end
    dav_in_ = 1'b1;
    tick();
    model_accept(100);
    for (int i = 0; i < 3; i++) send_value(10'd1, lat);
    checks++;
    if (data_out !== SW'(103)) begin
      errors++;
      $display("FAIL held_sum: data_out=%0d required 103", data_out);
    end
    recv_check("held");
  endtask

  task automatic test_reset_mid();
    int lat;
    send_value(10'd200, lat);
    send_value(10'd300, lat);
    reset_ = 1'b0;
    #1;
    checks++;
    if (rfd_in !== 1'b1 || dav_out_ !== 1'b1 || data_out !== '0) begin
      errors++;
      $display("FAIL mid_reset: rfd_in=%b dav_out_=%b data_out=%0d required 1 1 0",
               rfd_in, dav_out_, data_out);
    end
    #2;
    reset_ = 1'b1;
    model_reset();
    tick();
    for (int i = 0; i < 4; i++) send_value(10'd10, lat);
    checks++;
    if (data_out !== SW'(40)) begin
      errors++;
      $display("FAIL mid_sum: data_out=%0d required 40", data_out);
    end
    recv_check("mid_after");
  endtask

  task automatic test_random();
    int lat;
    for (int g = 0; g < 8; g++) begin
      rfd_out = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        send_value(DW'($urandom_range(0, 1023)), lat);
        repeat ($urandom_range(0, 2)) tick();
      end
      repeat ($urandom_range(0, 3)) tick();
      recv_check("rand");
    end
  endtask

`ifdef PERIMETER_ACCUMULATOR_MAX_EN
  task automatic test_max();
    int lat;
    logic [DW-1:0] a [4];
    a = '{10'd7, 10'd300, 10'd12, 10'd299};
    for (int i = 0; i < 4; i++) send_value(a[i], lat);
    checks++;
    if (data_out !== SW'(618) || max_out !== DW'(300)) begin
      errors++;
      $display("FAIL max_grp1: data_out=%0d max_out=%0d required 618 300", data_out, max_out);
    end
    recv_check("max1");
    for (int i = 1; i <= 4; i++) send_value(DW'(i), lat);
    checks++;
    if (max_out !== DW'(4)) begin
      errors++;
      $display("FAIL max_grp2: max_out=%0d required 4", max_out);
    end
    recv_check("max2");
  endtask
`endif

  initial begin
    reset_  = 1'b1;
    data_in = '0;
    dav_in_ = 1'b1;
    rfd_out = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_back_pressure();
    test_extremes();
    test_held_dav();
    test_reset_mid();
    test_random();
`ifdef PERIMETER_ACCUMULATOR_MAX_EN
    test_max();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perimeter_accumulator.md
Name: perimeter_accumulator

Overview:
- Downstream stage of the perimeter unit.
- Consumes 10-bit perimeter results over the dav_/rfd four-phase handshake.
- Accumulates N consecutive results into a sum.
- Presents the sum to a further consumer over the same handshake.
- Applies back-pressure to the perimeter unit while a sum is pending.

Parameters:
- N, 4: number of perimeter values per sum; integer 2..16.
- DATA_W, 10: input width; matches perimeter output.
- SUM_W, DATA_W+$clog2(N): output width. Derived; must not be overridden.

Ports:
- clock  input  1  system clock, rising edge.
- reset_  input  1  asynchronous active-low reset.
- data_in  input  DATA_W  perimeter value from upstream; stable while dav_in_=0.
- dav_in_  input  1  upstream data valid, active low.
- rfd_in  output  1  ready-for-data to upstream, active high.
- data_out  output  SUM_W  accumulated sum.
- dav_out_  output  1  data valid to downstream, active low.
- rfd_out  input  1  downstream ready-for-data, active high.
- max_out  output  DATA_W  largest value in current group; present only with the optional feature.

Behaviour:
- Reset (async, reset_=0): state=S_IN_WAIT, rfd_in=1, dav_out_=1, data_out=0, acc=0, cnt=0 (cnt width $clog2(N+1)), max_out=0.
- All outputs are registered; no combinational input-to-output paths.
- S_IN_WAIT (rfd_in=1): on a clock edge with dav_in_=0:
  - acc<=acc+data_in, cnt<=cnt+1, rfd_in<=0.
  - Go to S_IN_ACK.
  - Latency from dav_in_ low to rfd_in low: 1 clock.
- S_IN_ACK (rfd_in=0): on an edge with dav_in_=1:
  - If cnt==N: data_out<=acc, go to S_OUT_RDY; rfd_in stays 0.
  - Else: rfd_in<=1, go to S_IN_WAIT.
  - dav_in_ held low keeps the block in S_IN_ACK; the value is never counted twice.
- S_OUT_RDY (dav_out_=1): on an edge with rfd_out=1, dav_out_<=0 and go to S_OUT_ACK.
  - If rfd_out is already 1 on entry, dav_out_ falls on the next edge.
- S_OUT_ACK (dav_out_=0, data_out stable): on an edge with rfd_out=0:
  - dav_out_<=1, acc<=0, cnt<=0, rfd_in<=1.
  - Go to S_IN_WAIT.
- data_out holds its last value until the next group completes. It is not cleared after transfer.
- Arithmetic: unsigned, zero-extended to SUM_W. The maximum N*(2^DATA_W-1) fits in SUM_W, so no overflow is possible.
- Back-pressure: while in S_OUT_RDY/S_OUT_ACK, rfd_in=0. dav_in_=0 from upstream is ignored until S_IN_WAIT.
- Input value 0 is counted as a valid sample.
- Reset mid-operation: immediate return to reset values. A partial group and any undelivered sum are discarded.
- No other simultaneous events exist, because input and output phases are mutually exclusive.

Optional Feature:
- Macro: PERIMETER_ACCUMULATOR_MAX_EN.
- Enabled:
  - max_out port and a max register exist.
  - Max register resets to 0 and clears with acc.
  - On each accepted sample, max<=(data_in>max)?data_in:max.
  - max_out is updated together with data_out on entry to S_OUT_RDY and held with it.
- Disabled: no port, no register; behaviour otherwise identical.

Decomposition:
- Shared package perimeter_pkg:
  - PERIM_W=10 (shared with the perimeter unit).
  - State enum: S_IN_WAIT, S_IN_ACK, S_OUT_RDY, S_OUT_ACK, 2-bit encoding.
- Single module; no sub-module is warranted.

Test Plan:
- Basic group: N=4, rfd_out=1, inputs 20,30,40,50, each with full four-phase handshake -> data_out=140, dav_out_ low 1 clock after entering S_OUT_RDY. After rfd_out drops, dav_out_=1 and rfd_in=1.
- Back-pressure: rfd_out=0 during group completion, upstream presents a 5th value with dav_in_=0 -> rfd_in stays 0, dav_out_ stays 1, value not counted. Raising rfd_out delivers the sum, then the 5th value is accepted.
- Extremes: four inputs of 1023 -> data_out=4092 (12'hFFC), no wrap. Four zeros -> data_out=0, dav_out_ still asserted.
- Held dav_in_: dav_in_=0 for 6 clocks on one value (100) -> cnt increments once. Group 100,1,1,1 -> 103.
- Reset mid-operation: reset_ pulsed low after 2 of 4 samples -> rfd_in=1, dav_out_=1, data_out=0 asynchronously. The next 4 samples 10,10,10,10 -> 40.
- With PERIMETER_ACCUMULATOR_MAX_EN: inputs 7,300,12,299 -> data_out=618, max_out=300. Next group 1,2,3,4 -> max_out=4.
